// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC functional unit result path.
package mac_pkg;

  localparam int XLEN           = 32;
  localparam int TRANS_ID_BITS  = 4;
  localparam int MAC_FU_LATENCY = 3;

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } mac_result_t;

endpackage

// File: rtl/mac_wb_collector_if.sv
// Issue-credit, FU-result and writeback signals of the MAC result collector.
// The slave modport is the collector's view; master is the surrounding pipeline.
interface mac_wb_collector_if #(
  parameter int FIFO_DEPTH = 4
);
  import mac_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic                     fu_valid_i;
  logic [XLEN-1:0]          fu_result_i;
  logic [TRANS_ID_BITS-1:0] fu_trans_id_i;
  logic                     wb_valid_o;
  logic                     wb_ready_i;
  logic [XLEN-1:0]          wb_result_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic [CW-1:0]            credits_o;
  logic                     overflow_o;

  modport slave (
    input  issue_valid_i, fu_valid_i, fu_result_i, fu_trans_id_i, wb_ready_i,
    output issue_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, credits_o, overflow_o
  );

  modport master (
    output issue_valid_i, fu_valid_i, fu_result_i, fu_trans_id_i, wb_ready_i,
    input  issue_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, credits_o, overflow_o
  );

endinterface

// File: rtl/mac_result_fifo.sv
// Small synchronous FIFO of MAC results. Pointers carry one extra MSB so
// full and empty can be told apart; they wrap modulo 2*DEPTH.
module mac_result_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  mac_result_t data_i,
  output logic        full_o,
  output logic        empty_o,
  output mac_result_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  mac_result_t mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO only lands when the same cycle frees the head slot.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  // Head reads as zero when empty so idle writeback outputs are clean.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; clear empties the FIFO regardless of handshakes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mac_wb_collector.sv
// Collects stall-free MAC FU results into a FIFO, drains them to writeback,
// and hands out issue credits so the FIFO cannot be overrun.
module mac_wb_collector
  import mac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  mac_wb_collector_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CRED_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] credits_q, credits_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, fire;
  logic          fifo_full, fifo_empty;
  mac_result_t   fu_entry, head;

  assign fu_entry = '{result: bus.fu_result_i, trans_id: bus.fu_trans_id_i};

  // Flush masks every handshake; the credit check looks only at the register.
  assign bus.issue_ready_o = (credits_q != '0) & ~flush_i;
  assign fire = bus.issue_valid_i & bus.issue_ready_o;
  assign push = bus.fu_valid_i & ~flush_i;
  assign pop  = bus.wb_valid_o & bus.wb_ready_i & ~flush_i;

  mac_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (flush_i),
    .data_i  (fu_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign bus.wb_valid_o    = ~fifo_empty;
  assign bus.wb_result_o   = head.result;
  assign bus.wb_trans_id_o = head.trans_id;
  assign bus.credits_o     = credits_q;
  assign bus.overflow_o    = overflow_q;

  // Credit bookkeeping and sticky error detection.
  always_comb begin
    credits_d  = credits_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      credits_d = CRED_MAX;
    end else begin
      if (pop && !fire) begin
        if (credits_q == CRED_MAX) overflow_d = 1'b1;
        else                       credits_d  = credits_q + CRED_ONE;
      end else if (fire && !pop) begin
        credits_d = credits_q - CRED_ONE;
      end
      if (push && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  // Credit and overflow registers; overflow survives flush, only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      credits_q  <= CRED_MAX;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mac_wb_collector.sv
module tb_mac_wb_collector;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mac_wb_collector_if #(.FIFO_DEPTH(4)) bus ();

  mac_wb_collector #(.FIFO_DEPTH(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  typedef struct {
    logic        iv, fv;
    logic [31:0] res;
    logic [3:0]  id;
    logic        wr, fl;
    logic        e_wv;
    logic [31:0] e_res;
    logic [3:0]  e_id;
    logic [2:0]  e_cr;
    logic        e_ir, e_ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic fv, logic [31:0] res, logic [3:0] id,
                              logic wr, logic fl, logic e_wv, logic [31:0] e_res,
                              logic [3:0] e_id, logic [2:0] e_cr, logic e_ir, logic e_ov);
    vec_t v;
    v.iv = iv; v.fv = fv; v.res = res; v.id = id; v.wr = wr; v.fl = fl;
    v.e_wv = e_wv; v.e_res = e_res; v.e_id = e_id; v.e_cr = e_cr; v.e_ir = e_ir; v.e_ov = e_ov;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush             = 1'b0;
    bus.issue_valid_i = 1'b0;
    bus.fu_valid_i    = 1'b0;
    bus.fu_result_i   = '0;
    bus.fu_trans_id_i = '0;
    bus.wb_ready_i    = 1'b0;
  endtask

  // Drive one cycle of inputs, return to idle inputs just after the edge.
  task automatic cycle(logic iv, logic fv, logic [31:0] res, logic [3:0] id, logic wr, logic fl);
    bus.issue_valid_i = iv;
    bus.fu_valid_i    = fv;
    bus.fu_result_i   = res;
    bus.fu_trans_id_i = id;
    bus.wb_ready_i    = wr;
    flush             = fl;
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;

    // rows: iv fv res id wr fl | wv res id credits ready ovf
    // single op: issue, result three cycles later, then drain
    vecs.push_back(mk(1,0,32'h0,0,0,0, 0,32'h0,0,3,1,0));
    vecs.push_back(mk(0,0,32'h0,0,0,0, 0,32'h0,0,3,1,0));
    vecs.push_back(mk(0,0,32'h0,0,0,0, 0,32'h0,0,3,1,0));
    vecs.push_back(mk(0,1,32'h1234,5,0,0, 1,32'h1234,5,3,1,0));
    vecs.push_back(mk(0,0,32'h0,0,1,0, 0,32'h0,0,4,1,0));
    // backpressure: exhaust credits
    vecs.push_back(mk(1,0,32'h0,0,0,0, 0,32'h0,0,3,1,0));
    vecs.push_back(mk(1,0,32'h0,0,0,0, 0,32'h0,0,2,1,0));
    vecs.push_back(mk(1,0,32'h0,0,0,0, 0,32'h0,0,1,1,0));
    vecs.push_back(mk(1,0,32'h0,0,0,0, 0,32'h0,0,0,0,0));
    vecs.push_back(mk(1,0,32'h0,0,0,0, 0,32'h0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h101,1,0,0, 1,32'h101,1,0,0,0));
    vecs.push_back(mk(0,1,32'h102,2,0,0, 1,32'h101,1,0,0,0));
    vecs.push_back(mk(0,1,32'h103,3,0,0, 1,32'h101,1,0,0,0));
    vecs.push_back(mk(0,1,32'h104,4,0,0, 1,32'h101,1,0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,0, 1,32'h101,1,0,0,0));
    // pop at zero credits: no issue that cycle, credit arrives after
    vecs.push_back(mk(1,0,32'h0,0,1,0, 1,32'h102,2,1,1,0));
    // issue and pop together at one credit
    vecs.push_back(mk(1,0,32'h0,0,1,0, 1,32'h103,3,1,1,0));
    vecs.push_back(mk(1,0,32'h0,0,0,0, 1,32'h103,3,0,0,0));
    vecs.push_back(mk(0,1,32'h105,5,0,0, 1,32'h103,3,0,0,0));
    vecs.push_back(mk(0,1,32'h106,6,0,0, 1,32'h103,3,0,0,0));
    // full FIFO with push and pop together
    vecs.push_back(mk(0,1,32'h107,7,1,0, 1,32'h104,4,1,1,0));
    vecs.push_back(mk(0,0,32'h0,0,1,0, 1,32'h105,5,2,1,0));
    // flush with three buffered and one result arriving
    vecs.push_back(mk(1,1,32'h108,8,1,1, 0,32'h0,0,4,1,0));
    vecs.push_back(mk(0,0,32'h0,0,0,0, 0,32'h0,0,4,1,0));
    // overflow: fill, then force an extra result
    vecs.push_back(mk(1,0,32'h0,0,0,0, 0,32'h0,0,3,1,0));
    vecs.push_back(mk(1,0,32'h0,0,0,0, 0,32'h0,0,2,1,0));
    vecs.push_back(mk(1,0,32'h0,0,0,0, 0,32'h0,0,1,1,0));
    vecs.push_back(mk(1,0,32'h0,0,0,0, 0,32'h0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h209,9,0,0, 1,32'h209,9,0,0,0));
    vecs.push_back(mk(0,1,32'h20A,10,0,0, 1,32'h209,9,0,0,0));
    vecs.push_back(mk(0,1,32'h20B,11,0,0, 1,32'h209,9,0,0,0));
    vecs.push_back(mk(0,1,32'h20C,12,0,0, 1,32'h209,9,0,0,0));
    vecs.push_back(mk(0,1,32'h2FF,15,0,0, 1,32'h209,9,0,0,1));
    vecs.push_back(mk(0,0,32'h0,0,1,0, 1,32'h20A,10,1,1,1));
    vecs.push_back(mk(0,0,32'h0,0,1,0, 1,32'h20B,11,2,1,1));
    vecs.push_back(mk(0,0,32'h0,0,1,0, 1,32'h20C,12,3,1,1));
    vecs.push_back(mk(0,0,32'h0,0,1,0, 0,32'h0,0,4,1,1));
    vecs.push_back(mk(0,0,32'h0,0,1,0, 0,32'h0,0,4,1,1));

    // reset held for two cycles
    @(posedge clk); @(posedge clk); #1;
    check("rst.credits", 32'(bus.credits_o), 32'd4);
    check("rst.issue_ready", 32'(bus.issue_ready_o), 32'd1);
    check("rst.wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check("rst.overflow", 32'(bus.overflow_o), 32'd0);
    check("rst.wb_result", bus.wb_result_o, 32'd0);
    check("rst.wb_trans_id", 32'(bus.wb_trans_id_o), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].iv, vecs[i].fv, vecs[i].res, vecs[i].id, vecs[i].wr, vecs[i].fl);
      check($sformatf("v%0d.wb_valid", i), 32'(bus.wb_valid_o), 32'(vecs[i].e_wv));
      check($sformatf("v%0d.wb_result", i), bus.wb_result_o, vecs[i].e_res);
      check($sformatf("v%0d.wb_trans_id", i), 32'(bus.wb_trans_id_o), 32'(vecs[i].e_id));
      check($sformatf("v%0d.credits", i), 32'(bus.credits_o), 32'(vecs[i].e_cr));
      check($sformatf("v%0d.issue_ready", i), 32'(bus.issue_ready_o), 32'(vecs[i].e_ir));
      check($sformatf("v%0d.overflow", i), 32'(bus.overflow_o), 32'(vecs[i].e_ov));
    end

    // flush gates issue_ready combinationally and leaves overflow set
    flush = 1'b1;
    #1;
    check("flush.issue_ready_comb", 32'(bus.issue_ready_o), 32'd0);
    @(posedge clk); #1;
    idle(); #1;
    check("flush.overflow_kept", 32'(bus.overflow_o), 32'd1);
    check("flush.credits", 32'(bus.credits_o), 32'd4);

    // only reset clears overflow
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst2.overflow", 32'(bus.overflow_o), 32'd0);
    check("rst2.credits", 32'(bus.credits_o), 32'd4);
    rst_n = 1'b1;

    // reset mid-operation drops buffered results
    cycle(1, 1, 32'h33, 4'd3, 0, 0);
    check("midrst.pre_valid", 32'(bus.wb_valid_o), 32'd1);
    check("midrst.pre_credits", 32'(bus.credits_o), 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst.wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check("midrst.wb_result", bus.wb_result_o, 32'd0);
    check("midrst.credits", 32'(bus.credits_o), 32'd4);

    // uncredited result then pop: credit saturates and flags overflow
    cycle(0, 1, 32'h44, 4'd4, 0, 0);
    check("sat.wb_valid", 32'(bus.wb_valid_o), 32'd1);
    check("sat.pre_overflow", 32'(bus.overflow_o), 32'd0);
    cycle(0, 0, 32'h0, 4'd0, 1, 0);
    check("sat.credits", 32'(bus.credits_o), 32'd4);
    check("sat.overflow", 32'(bus.overflow_o), 32'd1);
    check("sat.wb_valid_after", 32'(bus.wb_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
